// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: handshake, ALU decode, forwarding.
// Optional operand forwarding is compiled in with `define ID_EX_FORWARD_EN.
package id_ex_pkg;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd,
  input  logic            alu_src,
  input  logic [1:0]      alu_op_in,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            branch,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            decode_err,
  output logic [31:0]     bubble_cnt
);

  logic            cap;
  logic [3:0]      dec_ctrl;
  logic            dec_err;
  logic [XLEN-1:0] q_rs1_data;
  logic [XLEN-1:0] q_rs2_data;
  logic [XLEN-1:0] q_imm;
  logic [RA_W-1:0] q_rs1;
  logic [RA_W-1:0] q_rs2;
  logic            q_alu_src;
  ex_ctrl_t        q_ctrl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  assign in_ready = !out_valid || out_ready;
  assign cap      = in_valid && in_ready && !flush;

  // R and I classes share the funct3 map; only R honours funct7_5
  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_err  = 1'b0;
    unique case (1'b1)
      alu_op_in == 2'b00: dec_ctrl = ALU_ADD;
      alu_op_in == 2'b01: dec_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000: dec_ctrl =
            (alu_op_in == 2'b10 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111: dec_ctrl = ALU_AND;
          3'b110: dec_ctrl = ALU_OR;
          3'b001: dec_ctrl = ALU_SLL;
          default: begin
            dec_ctrl = ALU_ADD;
            dec_err  = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      q_rs1_data <= '0;
      q_rs2_data <= '0;
      q_imm      <= '0;
      q_rs1      <= '0;
      q_rs2      <= '0;
      ex_rd      <= '0;
      q_alu_src  <= 1'b0;
      q_ctrl     <= '0;
      alu_ctrl   <= ALU_AND;
      decode_err <= 1'b0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (cap)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (cap) begin
        q_rs1_data <= rs1_data;
        q_rs2_data <= rs2_data;
        q_imm      <= imm;
        q_rs1      <= rs1;
        q_rs2      <= rs2;
        ex_rd      <= rd;
        q_alu_src  <= alu_src;
        q_ctrl     <= '{reg_write, mem_read, mem_write,
                        mem_to_reg, branch};
        alu_ctrl   <= dec_ctrl;
        decode_err <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bubble_cnt <= '0;
    else if (!out_valid && bubble_cnt != 32'hFFFF_FFFF)
      bubble_cnt <= bubble_cnt + 32'd1;
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is younger than MEM/WB, so it is tested first; x0 never forwards
  always_comb begin
    src1 = q_rs1_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == q_rs1)
      src1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == q_rs1)
      src1 = memwb_result;
  end

  always_comb begin
    src2 = q_rs2_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == q_rs2)
      src2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == q_rs2)
      src2 = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result,
                        q_rs1, q_rs2};
  assign src1 = q_rs1_data;
  assign src2 = q_rs2_data;
`endif

  assign alu_a         = src1;
  assign alu_b         = q_alu_src ? q_imm : src2;
  assign ex_store_data = src2;

  assign ex_reg_write  = q_ctrl.reg_write  && out_valid;
  assign ex_mem_read   = q_ctrl.mem_read   && out_valid;
  assign ex_mem_write  = q_ctrl.mem_write  && out_valid;
  assign ex_mem_to_reg = q_ctrl.mem_to_reg && out_valid;
  assign ex_branch     = q_ctrl.branch     && out_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations follow the
// forwarding build option when ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;
  localparam int XLEN = 64;
  localparam int RA_W = 5;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid, in_ready, flush;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic            alu_src;
  logic [1:0]      alu_op_in;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic            exmem_reg_write, memwb_reg_write;
  logic [RA_W-1:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]      alu_ctrl;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
  logic            ex_mem_to_reg, ex_branch, decode_err;
  logic [31:0]     bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_src(alu_src), .alu_op_in(alu_op_in),
    .funct3(funct3), .funct7_5(funct7_5),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .decode_err(decode_err),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    alu_src = 1'b0; alu_op_in = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; branch = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_a", alu_a, 64'd0);
    chk("rst_bub", 64'(bubble_cnt), 64'd0);

    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_ctrl", 64'(alu_ctrl), 64'd0);
    chk("idle_bub", 64'(bubble_cnt), 64'd5);
    chk("idle_rdy", 64'(in_ready), 64'd1);

    // R-type SUB
    in_valid = 1'b1; alu_op_in = 2'b10; funct3 = 3'b000; funct7_5 = 1'b1;
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    rs1_data = 64'd10; rs2_data = 64'd3; reg_write = 1'b1;
    @(negedge clk);
    chk("sub_valid", 64'(out_valid), 64'd1);
    chk("sub_ctrl", 64'(alu_ctrl), 64'b0110);
    chk("sub_a", alu_a, 64'd10);
    chk("sub_b", alu_b, 64'd3);
    chk("sub_rd", 64'(ex_rd), 64'd3);
    chk("sub_rw", 64'(ex_reg_write), 64'd1);
    chk("sub_err", 64'(decode_err), 64'd0);
    chk("sub_bub", 64'(bubble_cnt), 64'd6);

    // I-type SLLI
    alu_op_in = 2'b11; funct3 = 3'b001; funct7_5 = 1'b1;
    alu_src = 1'b1; imm = 64'd4; mem_write = 1'b1;
    @(negedge clk);
    chk("slli_ctrl", 64'(alu_ctrl), 64'b0111);
    chk("slli_b", alu_b, 64'd4);
    chk("slli_st", ex_store_data, 64'd3);
    chk("slli_mw", 64'(ex_mem_write), 64'd1);

    // unsupported I funct3
    funct3 = 3'b010; mem_write = 1'b0; branch = 1'b1;
    @(negedge clk);
    chk("bad_ctrl", 64'(alu_ctrl), 64'b0010);
    chk("bad_err", 64'(decode_err), 64'd1);
    chk("bad_br", 64'(ex_branch), 64'd1);

    // R-type ADD clears decode_err; then AND/OR
    alu_op_in = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0;
    alu_src = 1'b0; branch = 1'b0;
    @(negedge clk);
    chk("add_ctrl", 64'(alu_ctrl), 64'b0010);
    chk("add_err", 64'(decode_err), 64'd0);
    funct3 = 3'b111;
    @(negedge clk);
    chk("and_ctrl", 64'(alu_ctrl), 64'b0000);
    funct3 = 3'b110; alu_op_in = 2'b11;
    @(negedge clk);
    chk("ori_ctrl", 64'(alu_ctrl), 64'b0001);
    alu_op_in = 2'b01;
    @(negedge clk);
    chk("br_ctrl", 64'(alu_ctrl), 64'b0110);

    // forwarding: both stages target rs1
    alu_op_in = 2'b00;
    rs1 = 5'd5; rs1_data = 64'h11; rs2 = 5'd6; rs2_data = 64'h33;
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 64'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 64'hBB;
    @(negedge clk);
    chk("fwd_a", alu_a, FWD ? 64'hAA : 64'h11);
    chk("fwd_st0", ex_store_data, 64'h33);
    exmem_reg_write = 1'b0; memwb_rd = 5'd6;
    #1;
    chk("fwd_a2", alu_a, 64'h11);
    chk("fwd_b", alu_b, FWD ? 64'hBB : 64'h33);
    chk("fwd_st", ex_store_data, FWD ? 64'hBB : 64'h33);

    // x0 never forwarded
    @(negedge clk);
    rs1 = 5'd0; rs1_data = 64'h22; alu_op_in = 2'b01;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_reg_write = 1'b0;
    @(negedge clk);
    chk("x0_a", alu_a, 64'h22);

    // stall: held for 3 cycles, then back-to-back capture
    out_ready = 1'b0; exmem_reg_write = 1'b0;
    alu_op_in = 2'b00; rs1 = 5'd7; rs1_data = 64'd7;
    #1;
    chk("stall_rdy", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_a", alu_a, 64'h22);
      chk("hold_ctrl", 64'(alu_ctrl), 64'b0110);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_a", alu_a, 64'd7);
    chk("rel_ctrl", 64'(alu_ctrl), 64'b0010);
    chk("rel_bub", 64'(bubble_cnt), 64'd6);

    // flush beats the incoming capture
    flush = 1'b1; rs1_data = 64'h99; reg_write = 1'b1;
    @(negedge clk);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rw", 64'(ex_reg_write), 64'd0);
    chk("fl_a", alu_a, 64'd7);
    chk("fl_bub", 64'(bubble_cnt), 64'd6);
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_bub", 64'(bubble_cnt), 64'd8);

    // asynchronous reset mid-transfer
    in_valid = 1'b1; rs1_data = 64'h5; rd = 5'd9;
    @(negedge clk);
    chk("pre_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_a", alu_a, 64'd0);
    chk("ar_rd", 64'(ex_rd), 64'd0);
    chk("ar_bub", 64'(bubble_cnt), 64'd0);
    chk("ar_rw", 64'(ex_reg_write), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar2_valid", 64'(out_valid), 64'd0);
    chk("ar2_bub", 64'(bubble_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Captures decoded instruction fields under a valid/ready handshake.
- Decodes the 4-bit ALU control code.
- Resolves operand forwarding from EX/MEM and MEM/WB, then drives the ALU a, b and ALUOp inputs together with the EX-stage control bits.

Parameters:
XLEN, 64, datapath width
RA_W, 5, register-address width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  ID presents an instruction
in_ready  output  1  stage can accept
flush  input  1  kill held/incoming instruction (branch redirect)
rs1_data, rs2_data  input  XLEN  register-file read data
imm  input  XLEN  sign-extended immediate
rs1, rs2, rd  input  RA_W  register addresses
alu_src  input  1  1 = b from imm
alu_op_in  input  2  main-decoder class
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
reg_write, mem_read, mem_write, mem_to_reg, branch  input  1 each  control bits
exmem_reg_write  input  1  EX/MEM writes a register
exmem_rd  input  RA_W  EX/MEM destination
exmem_result  input  XLEN  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes a register
memwb_rd  input  RA_W  MEM/WB destination
memwb_result  input  XLEN  MEM/WB writeback value
out_valid  output  1  EX holds a valid instruction
out_ready  input  1  EX consumes this cycle
alu_a, alu_b  output  XLEN  ALU operands
alu_ctrl  output  4  ALU operation code
ex_store_data  output  XLEN  forwarded rs2 value for stores
ex_rd  output  RA_W  registered rd
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  output  1 each  registered control bits, gated by out_valid
decode_err  output  1  registered: unsupported R/I funct combination
bubble_cnt  output  32  cycles with out_valid = 0 since reset

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid = 0, bubble_cnt = 0, decode_err = 0.
  - All registered fields = 0, so alu_a = alu_b = ex_store_data = 0 and alu_ctrl = 4'b0000.
  - Reset asserted mid-transfer drops the held instruction; no partial state survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A capture occurs when in_valid && in_ready: out_valid = 1 on the next edge, all fields registered.
  - out_valid && out_ready && !capture → out_valid = 0.
  - A simultaneous consume and capture is back-to-back at full throughput.
- Flush:
  - flush high at an edge → out_valid = 0 and no capture, regardless of in_valid or out_ready.
  - Flush has priority over capture.
  - in_ready remains as defined; the flushed beat is discarded.
- Control gating: ex_* control outputs = registered bit AND out_valid, so no write enables leak from bubbles.
- ALU decode, registered at capture (latency 1):
  - alu_op_in 00 → 0010 (ADD, load/store).
  - alu_op_in 01 → 0110 (SUB, branch compare).
  - alu_op_in 10 (R-type): funct3 000 → 0010 if funct7_5 = 0, 0110 if funct7_5 = 1; 111 → 0000; 110 → 0001; 001 → 0111.
  - alu_op_in 11 (I-type): 000 → 0010; 111 → 0000; 110 → 0001; 001 → 0111; funct7_5 is ignored.
  - Any other R/I combination → 0010 with decode_err = 1 for that instruction; decode_err clears on the next capture.
- Forwarding (combinational on registered rs1/rs2):
  - src = exmem_result if exmem_reg_write && exmem_rd != 0 && exmem_rd == rsX.
  - Otherwise src = memwb_result under the same test on memwb.
  - Otherwise src = the registered data.
  - EX/MEM wins when both match. Register x0 is never forwarded.
- Operand routing:
  - alu_a = forwarded rs1.
  - alu_b = imm if alu_src, else forwarded rs2.
  - ex_store_data = forwarded rs2 always.
- bubble_cnt increments each cycle out_valid = 0 and saturates at 32'hFFFFFFFF.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined: the forwarding comparators are removed; alu_a, alu_b and ex_store_data use the registered rs1_data/rs2_data/imm only, and all exmem_*/memwb_* inputs are ignored. Software or the hazard unit must insert stalls.

Test Plan:
- Reset released, in_valid = 0 for 5 cycles → out_valid = 0, alu_ctrl = 0000, bubble_cnt = 5.
- R-type, alu_op_in = 10, funct3 = 000, funct7_5 = 1, rs1_data = 10, rs2_data = 3 → next cycle alu_ctrl = 0110, alu_a = 10, alu_b = 3.
- I-type slli, alu_op_in = 11, funct3 = 001, imm = 4 → alu_ctrl = 0111, alu_b = 4; funct3 = 010 → alu_ctrl = 0010, decode_err = 1.
- rs1 = 5, exmem_rd = 5 (result 0xAA), memwb_rd = 5 (result 0xBB), both reg_write → alu_a = 0xAA; rs1 = 0 with exmem_rd = 0 → alu_a = rs1_data.
- out_ready = 0 while out_valid, in_valid = 1 → in_ready = 0, outputs held stable for 3 cycles; then out_ready = 1 → new instruction captured same edge.
- flush = 1 coincident with in_valid = 1 and reg_write = 1 → out_valid = 0 next cycle, ex_reg_write = 0.
